// File: rtl/dispatch.sv
// Kernel block dispatcher: splits a latched thread count into fixed-size blocks and
// hands them to NUM_CORES compute cores, recycling each core as it retires its block.
module dispatch #(
  parameter int unsigned NUM_CORES         = 2,
  parameter int unsigned THREADS_PER_BLOCK = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [15:0]             thread_count,
  input  logic [NUM_CORES-1:0]    core_done,
  output logic [NUM_CORES-1:0]    core_start,
  output logic [NUM_CORES-1:0]    core_reset,
  output logic [NUM_CORES*16-1:0] core_block_id,
  output logic [NUM_CORES*5-1:0]  core_thread_count,
  output logic                    done
);

  localparam int unsigned TpbLog2 = $clog2(THREADS_PER_BLOCK);
  localparam logic [16:0] Tpb17   = 17'(THREADS_PER_BLOCK);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                     state_q, state_d;
  logic                       done_q, done_d;
  logic [15:0]                tc_q, tc_d;
  logic [16:0]                total_q, total_d;
  logic [16:0]                dispatched_q, dispatched_d;
  logic [16:0]                retired_q, retired_d;
  logic [NUM_CORES-1:0]       core_start_q, core_start_d;
  logic [NUM_CORES-1:0]       core_reset_q, core_reset_d;
  logic [NUM_CORES-1:0][15:0] block_id_q, block_id_d;
  logic [NUM_CORES-1:0][4:0]  block_tc_q, block_tc_d;

  // 17-bit ceil so 0xFFFF plus the rounding term cannot wrap.
  logic [16:0] blocks_calc;
  assign blocks_calc = ({1'b0, thread_count} + (Tpb17 - 17'd1)) >> TpbLog2;

  logic [16:0] block_base;
  logic [16:0] block_rem;

  always_comb begin
    state_d      = state_q;
    done_d       = done_q;
    tc_d         = tc_q;
    total_d      = total_q;
    dispatched_d = dispatched_q;
    retired_d    = retired_q;
    core_start_d = core_start_q;
    core_reset_d = core_reset_q;
    block_id_d   = block_id_q;
    block_tc_d   = block_tc_q;
    block_base   = '0;
    block_rem    = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          tc_d    = thread_count;
          total_d = blocks_calc;
          if (blocks_calc == 17'd0) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        // Cores are scanned in index order so lower cores take lower block ids.
        for (int i = 0; i < int'(NUM_CORES); i++) begin
          if (core_reset_q[i]) begin
            if (dispatched_d < total_q) begin
              block_base      = dispatched_d << TpbLog2;
              block_rem       = {1'b0, tc_q} - block_base;
              core_reset_d[i] = 1'b0;
              core_start_d[i] = 1'b1;
              block_id_d[i]   = dispatched_d[15:0];
              block_tc_d[i]   = (block_rem >= Tpb17) ? Tpb17[4:0] : block_rem[4:0];
              dispatched_d    = dispatched_d + 17'd1;
            end
          end else if (core_start_q[i] && core_done[i]) begin
            core_start_d[i] = 1'b0;
            core_reset_d[i] = 1'b1;
            retired_d       = retired_d + 17'd1;
          end
        end
        if (retired_d == total_q) begin
          state_d      = StDone;
          done_d       = 1'b1;
          core_start_d = '0;
          core_reset_d = '1;
        end
      end
      StDone: begin
        core_start_d = '0;
        core_reset_d = '1;
        if (!start) begin
          state_d      = StIdle;
          done_d       = 1'b0;
          total_d      = '0;
          dispatched_d = '0;
          retired_d    = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      done_q       <= 1'b0;
      tc_q         <= '0;
      total_q      <= '0;
      dispatched_q <= '0;
      retired_q    <= '0;
      core_start_q <= '0;
      core_reset_q <= '1;
      block_id_q   <= '0;
      block_tc_q   <= '0;
    end else begin
      state_q      <= state_d;
      done_q       <= done_d;
      tc_q         <= tc_d;
      total_q      <= total_d;
      dispatched_q <= dispatched_d;
      retired_q    <= retired_d;
      core_start_q <= core_start_d;
      core_reset_q <= core_reset_d;
      block_id_q   <= block_id_d;
      block_tc_q   <= block_tc_d;
    end
  end

  assign core_start        = core_start_q;
  assign core_reset        = core_reset_q;
  assign core_block_id     = block_id_q;
  assign core_thread_count = block_tc_q;
  assign done              = done_q;

endmodule

// File: doc/dispatch.md
Name: dispatch

Overview:
- Kernel block dispatcher. Sits directly downstream of the device control register and consumes its `thread_count` output.
- On `start`, splits `thread_count` into blocks of THREADS_PER_BLOCK threads. Hands blocks to NUM_CORES compute cores, recycling each core as it finishes.
- Signals kernel completion to the top level.

Parameters:
- NUM_CORES, 2, number of compute cores served (1..8).
- THREADS_PER_BLOCK, 4, threads per block; power of two, 1..16.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  level request to run the kernel.
- thread_count  input  16  total threads, from the device control register.
- core_done  input  NUM_CORES  per-core, high while core i has finished its block.
- core_start  output  NUM_CORES  per-core, high while core i owns a block.
- core_reset  output  NUM_CORES  per-core reset to the core, active-high.
- core_block_id  output  NUM_CORES*16  per-core block index; core i uses bits [16i+15:16i].
- core_thread_count  output  NUM_CORES*5  per-core active threads (1..THREADS_PER_BLOCK); core i uses bits [5i+4:5i].
- done  output  1  kernel complete.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE, done=0, core_start=0, core_reset=all 1s.
  - core_block_id=0, core_thread_count=0.
  - Internal total_blocks, blocks_dispatched and blocks_done = 0.
- Block arithmetic:
  - total_blocks = ceil(thread_count / THREADS_PER_BLOCK), computed as (thread_count + THREADS_PER_BLOCK-1) >> log2(THREADS_PER_BLOCK) in 17-bit arithmetic. This must not overflow at 0xFFFF.
  - total_blocks and the latched thread_count are frozen at the IDLE->RUN edge. Later changes on thread_count are ignored until the next IDLE.
  - Per-block thread count = min(THREADS_PER_BLOCK, thread_count_latched - block_id*THREADS_PER_BLOCK). Only the last block can be partial.
- IDLE:
  - When start=1 at a rising edge: latch thread_count, compute total_blocks.
  - If total_blocks=0, go directly to DONE (done=1 after that edge, no core touched).
  - Otherwise go to RUN.
- RUN, evaluated every edge independently for each core i:
  - Dispatch: if core_reset[i]=1 and blocks_dispatched < total_blocks:
    - core_reset[i]<=0, core_start[i]<=1.
    - core_block_id[i]<=blocks_dispatched, core_thread_count[i]<=per-block count.
    - Increment blocks_dispatched.
  - Priority: several cores eligible in one cycle each get a block in the same cycle. Lower index gets the lower block id; blocks_dispatched advances by the number granted.
  - Idle core: if core_reset[i]=1 and no blocks remain, the core stays in reset.
  - Retire: if core_start[i]=1 and core_done[i]=1:
    - core_start[i]<=0, core_reset[i]<=1, increment blocks_done (multiple retires in one cycle add together).
    - The core stays in reset exactly one cycle, then becomes eligible for dispatch again.
  - core_done[i] is ignored while core_start[i]=0.
  - When blocks_done (including this cycle's retires) equals total_blocks: go to DONE, done<=1 on that edge.
  - start falling during RUN is ignored; the kernel always runs to completion.
- DONE:
  - done=1, all core_reset=1, core_start=0.
  - When start=0: return to IDLE, done<=0, counters cleared.
  - start held high keeps DONE; there is no re-launch without start dropping.
- Latency:
  - start sampled at edge N; first core_start high after edge N+1.
  - done rises on the edge that retires the final block.
- Reset asserted mid-RUN aborts immediately to reset values; there is no partial completion.

Test Plan:
- Reset check: reset low, then release with start=0 -> done=0, core_start=00, core_reset=11, all ids 0, held 10 cycles.
- Partial last block: NUM_CORES=2, TPB=4, thread_count=10, start=1.
  - Edge N+1: core0 gets id0/count4 and core1 gets id1/count4.
  - Pulse core_done[0] -> core0 reset for 1 cycle, then gets id2/count2.
  - Retire all three blocks -> done=1 on the final retire edge; start=0 -> done=0 next edge.
- Zero threads: thread_count=0, start=1 -> done=1 after one edge, core_start never asserted.
- Simultaneous retire and frozen input: thread_count=8, both cores assert core_done in the same cycle -> blocks_done=2, done=1 on that edge. Changing thread_count mid-RUN has no effect.
- Abort and relaunch: reset low while core0 is busy -> all outputs at reset values immediately. Relaunch with thread_count=4 -> only core0 dispatched (id0/count4); core1 stays in reset.
- Overflow boundary: thread_count=0xFFFF with TPB=4 -> total_blocks=16384, last block id 16383 with count 3; no counter wrap.
